// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter.
// A byte FIFO feeds a start/data/stop serializer driving the tx pin.
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned FIFO_AW      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       w_data,
    input  logic             write_enable,
    output logic             tx,
    output logic             tx_busy,
    output logic             fifo_full,
    output logic [FIFO_AW:0] fifo_count,
    output logic             overflow
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;

    localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] BAUD_ONE = 16'd1;

    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
    localparam logic [FIFO_AW:0]   CNT_ONE = (FIFO_AW + 1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e             state_q;
    logic [15:0]        baud_q;
    logic [2:0]         bit_q;
    logic [7:0]         shift_q;
    logic               tx_q;

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wptr_q;
    logic [FIFO_AW-1:0] wptr_d;
    logic [FIFO_AW-1:0] rptr_q;
    logic [FIFO_AW-1:0] rptr_d;
    logic [FIFO_AW:0]   count_q;
    logic [FIFO_AW:0]   count_d;
    logic               ovf_q;
    logic               ovf_d;

    logic               full;
    logic               not_empty;
    logic               baud_done;
    logic               push;
    logic               pop;

    // Handshake decode from registered state only.
    // Count never exceeds DEPTH, so its MSB alone flags full.
    always_comb begin
        full      = count_q[FIFO_AW];
        not_empty = |count_q;
        baud_done = (baud_q == BAUD_MAX);
        push      = write_enable & ~full;
        pop       = not_empty
                  & ((state_q == IDLE)
                  | ((state_q == STOP) & baud_done));
    end

    // FIFO pointer, occupancy and overflow next-state.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q | (write_enable & full);
        if (push) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_ONE;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // FIFO control registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // FIFO storage; contents need no reset, pointers gate them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= w_data;
        end
    end

    // Serializer: frame sequencing with a registered tx output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    baud_q <= '0;
                    tx_q   <= 1'b1;
                    if (pop) begin
                        shift_q <= mem_q[rptr_q];
                        state_q <= START;
                        tx_q    <= 1'b0;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + BAUD_ONE;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_ONE;
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud_q <= '0;
                        if (pop) begin
                            shift_q <= mem_q[rptr_q];
                            state_q <= START;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    // Outputs are registers or simple decodes of them.
    always_comb begin
        tx         = tx_q;
        tx_busy    = (state_q != IDLE) | not_empty;
        fifo_full  = full;
        fifo_count = count_q;
        overflow   = ovf_q;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo.
// Small baud divider and a 4-entry FIFO keep frames short.
module tb_uart_tx_fifo;

    localparam int CPB = 4;
    localparam int AW  = 2;

    logic          clk;
    logic          rst;
    logic [7:0]    wd;
    logic          we;
    logic          tx;
    logic          tx_busy;
    logic          fifo_full;
    logic [AW:0]   fifo_count;
    logic          overflow;

    int n_chk;
    int n_fail;
    int rst_cnt;
    int bad_cnt;

    logic [7:0] rx_q [$];
    logic [7:0] exp_q [$];
    longint     st_q [$];

    typedef struct packed {
        logic       i_we;
        logic [7:0] i_d;
        logic       e_tx;
        logic       e_busy;
        logic [2:0] e_cnt;
    } vec_t;

    vec_t tv [42];

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_AW(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .w_data(wd),
        .write_enable(we),
        .tx(tx),
        .tx_busy(tx_busy),
        .fifo_full(fifo_full),
        .fifo_count(fifo_count),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge rst) rst_cnt++;

    // Line receiver: samples each bit mid-cell.
    initial begin
        logic [7:0] b;
        longint     t0;
        int         r0;
        int         bad;
        forever begin
            @(negedge clk);
            if (rst && tx == 1'b0) begin
                t0  = $time;
                r0  = rst_cnt;
                bad = 0;
                repeat (2) @(negedge clk);
                if (tx !== 1'b0) bad = 1;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                if (tx !== 1'b1) bad = 1;
                if (r0 == rst_cnt) begin
                    rx_q.push_back(b);
                    st_q.push_back(t0);
                    bad_cnt += bad;
                end
            end
        end
    end

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        we = 1'b1;
        wd = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (tx_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain", {31'd0, tx_busy}, 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_frames(input string nm);
        chk({nm, " nframes"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rx_q.size())
                chk($sformatf("%s byte%0d", nm, i),
                    {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
        end
        chk({nm, " framing"}, bad_cnt, 0);
        bad_cnt = 0;
        rx_q.delete();
        exp_q.delete();
        st_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] pat;
        logic [2:0] c3 [6];
        logic       f3 [6];
        logic       o3 [6];
        int         n;

        n_chk   = 0;
        n_fail  = 0;
        bad_cnt = 0;
        rst     = 1'b0;
        we      = 1'b0;
        wd      = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst tx", {31'd0, tx}, 32'd1);
        chk("rst busy", {31'd0, tx_busy}, 32'd0);
        chk("rst full", {31'd0, fifo_full}, 32'd0);
        chk("rst count", {29'd0, fifo_count}, 32'd0);
        chk("rst ovf", {31'd0, overflow}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // 1: single byte 0xA5, per-cycle table
        pat   = 8'hA5;
        tv[0] = '{1'b1, 8'hA5, 1'b1, 1'b1, 3'd1};
        for (int i = 1; i < 5; i++)
            tv[i] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd0};
        for (int b = 0; b < 8; b++)
            for (int j = 0; j < 4; j++)
                tv[5 + 4 * b + j] =
                    '{1'b0, 8'h00, pat[b], 1'b1, 3'd0};
        for (int i = 37; i < 41; i++)
            tv[i] = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd0};
        tv[41] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0};

        for (int i = 0; i < 42; i++) begin
            we = tv[i].i_we;
            wd = tv[i].i_d;
            @(negedge clk);
            chk($sformatf("t1 tx c%0d", i),
                {31'd0, tx}, {31'd0, tv[i].e_tx});
            chk($sformatf("t1 busy c%0d", i),
                {31'd0, tx_busy}, {31'd0, tv[i].e_busy});
            chk($sformatf("t1 cnt c%0d", i),
                {29'd0, fifo_count}, {29'd0, tv[i].e_cnt});
        end
        we = 1'b0;
        repeat (4) @(negedge clk);
        exp_q.push_back(8'hA5);
        check_frames("t1");

        // 2: back-to-back 0x00, 0xFF
        we = 1'b1;
        wd = 8'h00;
        @(negedge clk);
        chk("t2 cnt1", {29'd0, fifo_count}, 32'd1);
        wd = 8'hFF;
        @(negedge clk);
        chk("t2 cnt2", {29'd0, fifo_count}, 32'd1);
        we = 1'b0;
        n = 0;
        while (fifo_count != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t2 pop2 delay", n, 40);
        wait_idle(200);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        if (st_q.size() == 2)
            chk("t2 gap", 32'(st_q[1] - st_q[0]), 32'd400);
        check_frames("t2");

        // 3: overflow, 6 pushes into 4 entries
        c3 = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        f3 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        o3 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            we = 1'b1;
            wd = 8'(i + 1);
            @(negedge clk);
            chk($sformatf("t3 cnt p%0d", i),
                {29'd0, fifo_count}, {29'd0, c3[i]});
            chk($sformatf("t3 full p%0d", i),
                {31'd0, fifo_full}, {31'd0, f3[i]});
            chk($sformatf("t3 ovf p%0d", i),
                {31'd0, overflow}, {31'd0, o3[i]});
        end
        we = 1'b0;
        wait_idle(400);
        for (int i = 1; i <= 5; i++)
            exp_q.push_back(8'(i));
        for (int i = 1; i < st_q.size(); i++)
            chk($sformatf("t3 gap%0d", i),
                32'(st_q[i] - st_q[i - 1]), 32'd400);
        chk("t3 ovf sticky", {31'd0, overflow}, 32'd1);
        check_frames("t3");

        // 5: reset mid-frame, overflow still set
        push(8'hA1);
        push(8'hB2);
        push(8'hC3);
        chk("t5 cnt", {29'd0, fifo_count}, 32'd2);
        repeat (16) @(negedge clk);
        chk("t5 bit3", {31'd0, tx}, 32'd0);
        #1 rst = 1'b0;
        #1;
        chk("t5 rst tx", {31'd0, tx}, 32'd1);
        chk("t5 rst cnt", {29'd0, fifo_count}, 32'd0);
        chk("t5 rst busy", {31'd0, tx_busy}, 32'd0);
        chk("t5 rst ovf", {31'd0, overflow}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            chk($sformatf("t5 idle c%0d", i),
                {31'd0, tx}, 32'd1);
        end
        chk("t5 no frame", rx_q.size(), 0);
        push(8'h5A);
        wait_idle(200);
        exp_q.push_back(8'h5A);
        check_frames("t5");

        // 4: wrap-around, 3 then 4 bytes
        do_reset();
        push(8'h11);
        push(8'h22);
        push(8'h33);
        wait_idle(300);
        push(8'h44);
        push(8'h55);
        push(8'h66);
        push(8'h77);
        chk("t4 ovf", {31'd0, overflow}, 32'd0);
        wait_idle(300);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h66);
        exp_q.push_back(8'h77);
        check_frames("t4");

        // 6: w_data changes after push
        we = 1'b1;
        wd = 8'h3C;
        @(negedge clk);
        we = 1'b0;
        wd = 8'hC3;
        wait_idle(200);
        exp_q.push_back(8'h3C);
        check_frames("t6");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
